// File: rtl/mmio_register_bank_pkg.sv
// Shared constants, mode codes and lane helpers for the MMIO register bank.
// Bus code values mirror the data-memory request/response encoding.
package mmio_register_bank_pkg;

    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int MEM_CODE_W  = 2;
    localparam int MEM_COUNT_W = 2;
    localparam int MMIO_MODE_W = 2;
    localparam int MAX_REGS    = 64;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID    = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 2'd2;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 2'd3;

    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

    typedef enum logic [MMIO_MODE_W-1:0] {
        MMIO_MODE_RO   = 2'd0,
        MMIO_MODE_RW   = 2'd1,
        MMIO_MODE_W1C  = 2'd2,
        MMIO_MODE_RSVD = 2'd3
    } mmio_mode_e;

    // Mode of word idx; the reserved code behaves like RO.
    function automatic mmio_mode_e mode_of(
        input logic [2*MAX_REGS-1:0] modes,
        input int                    idx
    );
        logic [MMIO_MODE_W-1:0] m;
        m = modes[2*idx +: 2];
        if (m == MMIO_MODE_RW)
            return MMIO_MODE_RW;
        else if (m == MMIO_MODE_W1C)
            return MMIO_MODE_W1C;
        else
            return MMIO_MODE_RO;
    endfunction

    // Byte enables of an access given its size and byte offset.
    function automatic logic [3:0] be_of(
        input logic [MEM_COUNT_W-1:0] cnt,
        input logic [1:0]             off
    );
        logic [3:0] be;
        be = 4'b0000;
        unique case (cnt)
            MEM_COUNT_BYTE: be = 4'b0001 << off;
            MEM_COUNT_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            MEM_COUNT_WORD: be = 4'b1111;
            default:        be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mmio_reg_word.sv
// One 32-bit MMIO storage word: RO (no storage), RW (byte-enable write)
// or W1C (sticky hw set, byte-enable write-one-to-clear).
module mmio_reg_word
    import mmio_register_bank_pkg::*;
#(
    parameter mmio_mode_e        MODE      = MMIO_MODE_RO,
    parameter logic [WORD_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              i_wr_en,
    input  logic [3:0]        i_be,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [WORD_W-1:0] i_hw_set,
    output logic [WORD_W-1:0] o_value,
    output logic [WORD_W-1:0] o_next
);

    logic [WORD_W-1:0] w_bit_en;

    assign w_bit_en = {{8{i_be[3]}}, {8{i_be[2]}},
                       {8{i_be[1]}}, {8{i_be[0]}}};

    generate
        if (MODE == MMIO_MODE_RW) begin : g_rw
            logic [WORD_W-1:0] r_value;
            logic [WORD_W-1:0] w_next;
            logic              w_unused;

            assign w_unused = ^i_hw_set;

            // Replace only the enabled bytes on a store.
            always_comb begin
                w_next = r_value;
                if (i_wr_en)
                    w_next = (r_value & ~w_bit_en) | (i_wr_data & w_bit_en);
            end

            // Software-owned storage, preset to its reset value.
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn)
                    r_value <= RESET_VAL;
                else
                    r_value <= w_next;
            end

            assign o_value = r_value;
            assign o_next  = w_next;
        end else if (MODE == MMIO_MODE_W1C) begin : g_w1c
            logic [WORD_W-1:0] r_value;
            logic [WORD_W-1:0] w_clr;
            logic [WORD_W-1:0] w_next;

            // Clear where a 1 is written; hw set wins over a same-cycle clear.
            always_comb begin
                w_clr = '0;
                if (i_wr_en)
                    w_clr = i_wr_data & w_bit_en;
                w_next = (r_value & ~w_clr) | i_hw_set;
            end

            // Sticky status bits.
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn)
                    r_value <= '0;
                else
                    r_value <= w_next;
            end

            assign o_value = r_value;
            assign o_next  = w_next;
        end else begin : g_ro
            logic w_unused;

            assign w_unused = ^{clk, aresetn, i_wr_en, w_bit_en,
                                i_wr_data, i_hw_set};
            assign o_value  = '0;
            assign o_next   = '0;
        end
    endgenerate

endmodule

// File: rtl/mmio_register_bank.sv
// Memory-mapped register bank with per-word RO/RW/W1C modes.
// Optional irq mask word and interrupt output: define MMIO_REGS_IRQ_EN.
module mmio_register_bank
    import mmio_register_bank_pkg::*;
#(
    parameter int                         REG_COUNT   = 4,
    parameter logic [ADDR_W-1:0]          ADDR_START  = '0,
    parameter logic [2*REG_COUNT-1:0]     REG_MODE    = '0,
    parameter logic [REG_COUNT*WORD_W-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [ADDR_W-1:0]             i_req_addr,
    input  logic [MEM_COUNT_W-1:0]        i_req_count,
    input  logic                          i_req_wr_en,
    input  logic [WORD_W-1:0]             i_req_wr_data,
    output logic [WORD_W-1:0]             o_res_rd_data,
    output logic [MEM_CODE_W-1:0]         o_res_code,
    input  logic [REG_COUNT*WORD_W-1:0]   i_hw_values,
    input  logic [REG_COUNT*WORD_W-1:0]   i_hw_set,
    output logic [REG_COUNT*WORD_W-1:0]   o_sw_regs,
    output logic                          o_irq
);

    localparam int IDX_W = ADDR_W - 2;
`ifdef MMIO_REGS_IRQ_EN
    localparam int LAST = REG_COUNT;
`else
    localparam int LAST = REG_COUNT - 1;
`endif
    localparam logic [IDX_W-1:0] BASE_IDX = ADDR_START[ADDR_W-1:2];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);
    localparam logic [2*MAX_REGS-1:0] MODES = (2*MAX_REGS)'(REG_MODE);

    logic [IDX_W-1:0]            w_idx;
    logic [1:0]                  w_off;
    logic                        w_access;
    logic                        w_misalign;
    logic                        w_in_range;
    logic [WORD_W-1:0]           w_sel_word;
    logic                        w_sel_ro;
    logic                        w_store;
    logic [3:0]                  w_be;
    logic [WORD_W-1:0]           w_wdata;
    logic [WORD_W-1:0]           w_lane;
    logic [MEM_CODE_W-1:0]       w_code_nxt;
    logic [WORD_W-1:0]           w_data_nxt;
    logic [REG_COUNT*WORD_W-1:0] w_stored;
    logic [REG_COUNT*WORD_W-1:0] w_next;
    logic [WORD_W-1:0]           w_rd_vals [REG_COUNT];
    logic [REG_COUNT-1:0]        w_word_we;
    logic                        w_unused;

    logic [WORD_W-1:0]           r_res_rd_data;
    logic [MEM_CODE_W-1:0]       r_res_code;

    assign w_idx      = i_req_addr[ADDR_W-1:2] - BASE_IDX;
    assign w_off      = i_req_addr[1:0];
    assign w_access   = (i_req_count != MEM_COUNT_NONE);
    assign w_misalign = ((i_req_count == MEM_COUNT_HALF) && w_off[0])
                     || ((i_req_count == MEM_COUNT_WORD) && (w_off != 2'b00));
    assign w_in_range = (w_idx <= LAST_IDX);
    assign w_be       = be_of(i_req_count, w_off);

`ifdef MMIO_REGS_IRQ_EN
    logic [WORD_W-1:0]    w_mask;
    logic [WORD_W-1:0]    w_mask_next;
    logic                 w_mask_we;
    logic [REG_COUNT-1:0] w_irq_bits;
    logic                 r_irq;

    assign w_mask_we = w_store && (w_idx == IDX_W'(REG_COUNT));

    mmio_reg_word #(
        .MODE      (MMIO_MODE_RW),
        .RESET_VAL ('0)
    ) u_mask (
        .clk       (clk),
        .aresetn   (aresetn),
        .i_wr_en   (w_mask_we),
        .i_be      (w_be),
        .i_wr_data (w_wdata),
        .i_hw_set  ('0),
        .o_value   (w_mask),
        .o_next    (w_mask_next)
    );
`endif

    // Shift store data into the addressed lane.
    always_comb begin
        w_wdata = i_req_wr_data;
        unique case (i_req_count)
            MEM_COUNT_BYTE:
                w_wdata = {24'b0, i_req_wr_data[7:0]} << {w_off, 3'b000};
            MEM_COUNT_HALF:
                w_wdata = {16'b0, i_req_wr_data[15:0]} << {w_off[1], 4'b0000};
            default:
                w_wdata = i_req_wr_data;
        endcase
    end

    // Select the addressed word and whether it rejects stores.
    always_comb begin
        w_sel_word = '0;
        w_sel_ro   = 1'b1;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_sel_word = w_rd_vals[i];
                w_sel_ro   = (mode_of(MODES, i) == MMIO_MODE_RO);
            end
        end
`ifdef MMIO_REGS_IRQ_EN
        if (w_idx == IDX_W'(REG_COUNT)) begin
            w_sel_word = w_mask;
            w_sel_ro   = 1'b0;
        end
`endif
    end

    assign w_store = w_access && i_req_wr_en && !w_misalign
                  && w_in_range && !w_sel_ro;

    genvar g;
    generate
        for (g = 0; g < REG_COUNT; g++) begin : g_word
            localparam mmio_mode_e MODE = mode_of(MODES, g);

            assign w_word_we[g] = w_store && (w_idx == IDX_W'(g));

            mmio_reg_word #(
                .MODE      (MODE),
                .RESET_VAL (RESET_VALUE[g*WORD_W +: WORD_W])
            ) u_word (
                .clk       (clk),
                .aresetn   (aresetn),
                .i_wr_en   (w_word_we[g]),
                .i_be      (w_be),
                .i_wr_data (w_wdata),
                .i_hw_set  (i_hw_set[g*WORD_W +: WORD_W]),
                .o_value   (w_stored[g*WORD_W +: WORD_W]),
                .o_next    (w_next[g*WORD_W +: WORD_W])
            );

            if (MODE == MMIO_MODE_RO) begin : g_rd_hw
                assign w_rd_vals[g] = i_hw_values[g*WORD_W +: WORD_W];
            end else begin : g_rd_sw
                assign w_rd_vals[g] = w_stored[g*WORD_W +: WORD_W];
            end

`ifdef MMIO_REGS_IRQ_EN
            if (MODE == MMIO_MODE_W1C) begin : g_irq_w1c
                assign w_irq_bits[g] =
                    |(w_next[g*WORD_W +: WORD_W] & w_mask_next);
            end else begin : g_irq_none
                assign w_irq_bits[g] = 1'b0;
            end
`endif
        end
    endgenerate

    assign o_sw_regs = w_stored;
    assign w_unused  = ^{i_hw_values, i_hw_set, w_next};

    // Extract the addressed lane, zero-extended.
    always_comb begin
        w_lane = w_sel_word;
        unique case (i_req_count)
            MEM_COUNT_BYTE:
                w_lane = {24'b0, 8'(w_sel_word >> {w_off, 3'b000})};
            MEM_COUNT_HALF:
                w_lane = {16'b0, 16'(w_sel_word >> {w_off[1], 4'b0000})};
            default:
                w_lane = w_sel_word;
        endcase
    end

    // Response code and data for the current request.
    always_comb begin
        w_code_nxt = MEM_CODE_INVALID;
        w_data_nxt = '0;
        if (!w_access)
            w_code_nxt = MEM_CODE_INVALID;
        else if (w_misalign)
            w_code_nxt = MEM_CODE_MISALIGNED;
        else if (!w_in_range)
            w_code_nxt = MEM_CODE_INVALID;
        else if (i_req_wr_en)
            w_code_nxt = w_sel_ro ? MEM_CODE_INVALID : MEM_CODE_WRITE;
        else begin
            w_code_nxt = MEM_CODE_READ;
            w_data_nxt = w_lane;
        end
    end

    // One-cycle registered response.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_res_code    <= MEM_CODE_INVALID;
            r_res_rd_data <= '0;
        end else begin
            r_res_code    <= w_code_nxt;
            r_res_rd_data <= w_data_nxt;
        end
    end

    assign o_res_code    = r_res_code;
    assign o_res_rd_data = r_res_rd_data;

`ifdef MMIO_REGS_IRQ_EN
    // Interrupt from next-state W1C bits under next-state mask.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            r_irq <= 1'b0;
        else
            r_irq <= |w_irq_bits;
    end

    assign o_irq = r_irq;
`else
    assign o_irq = 1'b0;
`endif

endmodule
